aes_key_schedule: RTL and testbench
===================================

// Module: aes_key_schedule
// PURPOSE
//  Iterative AES-128 key expander: sequentially generates round keys 0..10 from a 128-bit cipher key.
//  Streams one round key per accepted handshake to the round datapath; round key 10 feeds the final
//  (SubBytes/ShiftRows/AddRoundKey) stage. Replaces a 1408-bit combinational expansion with one
//  128-bit register.
// PARAMETERS
//  NR     10   number of rounds; fixed at 10 for AES-128, other values unsupported
//  KEY_W  128  key / round-key width; fixed at 128
// PORTS
//  clk             in   1        single clock, rising edge
//  rst             in   1        asynchronous, active-high reset
//  start           in   1        load key and begin expansion; sampled only in IDLE
//  key             in   [0:127]  cipher key; sampled on the cycle start is accepted; bit 0 = MSB of byte 0
//  busy            out  1        high from cycle after start accepted until last key consumed
//  roundKey_valid  out  1        roundKey / round_idx hold a valid key
//  roundKey_ready  in   1        consumer accepts the key when valid & ready
//  round_idx       out  [3:0]    index of the presented round key, 0..NR
//  roundKey        out  [0:127]  current round key
//  done            out  1        one-cycle pulse on the cycle round key NR is accepted
// BEHAVIOUR
//  Reset: busy=0, roundKey_valid=0, round_idx=0, roundKey=0, done=0, rcon=8'h01, FSM=IDLE.
//  FSM states: IDLE, RUN.
//   IDLE: start=1 -> roundKey<=key, round_idx<=0, rcon<=8'h01, valid<=1, busy<=1, go RUN.
//         start=0 -> stay; outputs hold reset values (roundKey may retain last key; valid=0).
//   RUN:  valid & ready & round_idx<NR -> roundKey<=next(roundKey, rcon), round_idx+=1, rcon<=xtime(rcon).
//         valid & ready & round_idx==NR -> done=1 that cycle (combinational on accept),
//           next cycle valid=0, busy=0, FSM=IDLE.
//         ready=0 -> roundKey, round_idx, rcon held stable (no change while valid & !ready).
//  Latency: key 0 valid 1 cycle after start; with ready tied high, key r valid at cycle 1+r, done
//    at cycle 11 after start; new start accepted the cycle after done (back-to-back = 12-cycle period).
//  next(): words w0..w3 = roundKey[0:31]..[96:127];
//    t  = SubWord(RotWord(w3)) ^ {rcon,24'h0};  RotWord = {w3[8:31],w3[0:7]}
//    w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
//  rcon: 8-bit GF(2^8) doubling, xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00);
//    sequence 01,02,04,08,10,20,40,80,1B,36 for rounds 1..10.
//  start while busy: ignored, no effect on in-flight expansion or on key register.
//  start same cycle as final accept: ignored (FSM still RUN); must be re-asserted in IDLE.
//  Reset mid-expansion: immediate return to reset values; no done pulse; partial keys discarded.
//  round_idx never exceeds NR; no wrap-around.
//  roundKey_valid must not depend combinationally on roundKey_ready; done is the only
//    combinational output (valid & ready & round_idx==NR).
// STRUCTURE
//  Shared package aes_pkg: state enum (IDLE, RUN), SBOX 256x8 constant table, xtime() function,
//    RCON_INIT=8'h01, AES_NR=10; same S-box table used by the SubBytes stage.
//  Sub-module aes_sub_word: 32-bit SubWord, four parallel aes_pkg S-box lookups, purely combinational.
//  Top: FSM, round counter, rcon register, 128-bit key register, next-key XOR chain.
// TESTING
//  FIPS-197 A.1: key 2b7e151628aed2a6abf7158809cf4f3c, ready=1 -> key1 a0fafe1788542cb123a339392a6c7605,
//    key10 d014f9a8c9ee2589e13f0cc8b6630ca6, done pulses with round_idx=10.
//  Key all-zero -> key1 62636363626363636263636362636363, key10 b4ef5bcb3e92e21123e951cf6f8f188e.
//  Backpressure: ready toggled randomly -> roundKey/round_idx stable while !ready; same 11 keys in order.
//  start pulsed at round_idx=5 -> ignored; sequence and final key unchanged.
//  rst asserted at round_idx=4 -> all outputs reset values same cycle (async); new start yields key0 next cycle.
//  Back-to-back: second start the cycle after done -> new key0 valid next cycle; no stale valid between runs.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, state type, S-box table and GF(2^8) helpers
//
// Purpose: items shared by the key schedule and the round datapath.
//   AES_NR     number of AES-128 rounds
//   AES_KEY_W  key / round-key width
//   RCON_INIT  round constant used for round key 1
//   ks_state_e key-schedule FSM states (IDLE, RUN)
//   SBOX       forward S-box; the SubBytes stage uses the same table
//   xtime()    GF(2^8) multiply by 2 (AES polynomial 0x11B)
//   sbox_lookup() single-byte S-box substitution

package aes_pkg;

    localparam int         AES_NR    = 10;
    localparam int         AES_KEY_W = 128;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ks_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] sbox_lookup(input logic [7:0] x);
        return SBOX[x];
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// rtl/aes_sub_word.sv - 32-bit SubWord, four parallel S-box lookups
//
// Purpose: purely combinational byte-wise S-box substitution of one word.
// Ports:
//   word_i  [31:0]  input word, bits [31:24] are the first (leftmost) byte
//   word_o  [31:0]  substituted word, same byte order

module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign word_o[8*b +: 8] = sbox_lookup(word_i[8*b +: 8]);
    end

endmodule

// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - iterative AES-128 key expander, one round key per handshake
//
// Purpose: holds a single 128-bit round key and advances it by one AES key
//   expansion step each time the consumer accepts the presented key.
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-high reset
//   start           load key and begin expansion (only honoured in IDLE)
//   key   [0:127]   cipher key, bit 0 is the MSB of byte 0
//   busy            expansion in flight
//   roundKey_valid  roundKey / round_idx hold a valid key
//   roundKey_ready  consumer accepts the key when valid & ready
//   round_idx [3:0] index of the presented round key, 0..NR
//   roundKey [0:127] presented round key
//   done            combinational pulse on acceptance of round key NR

module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int NR    = AES_NR,
    parameter int KEY_W = AES_KEY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [0:KEY_W-1] key,
    output logic             busy,
    output logic             roundKey_valid,
    input  logic             roundKey_ready,
    output logic [3:0]       round_idx,
    output logic [0:KEY_W-1] roundKey,
    output logic             done
);

    localparam logic [3:0] LAST_IDX = 4'(NR);

    ks_state_e        state_q, state_d;
    logic [0:KEY_W-1] key_q,   key_d;
    logic [3:0]       idx_q,   idx_d;
    logic [7:0]       rcon_q,  rcon_d;

    logic             accept;
    logic             last_key;

    // Next-round key derivation from the currently held key.
    logic [0:31]      w0, w1, w2, w3;
    logic [0:31]      n0, n1, n2, n3;
    logic [31:0]      rot_w;
    logic [31:0]      sub_w;
    logic [31:0]      t_w;
    logic [0:KEY_W-1] next_key;

    assign w0 = key_q[0:31];
    assign w1 = key_q[32:63];
    assign w2 = key_q[64:95];
    assign w3 = key_q[96:127];

    // RotWord: first byte of w3 moves to the end.
    assign rot_w = {w3[8:31], w3[0:7]};

    aes_sub_word u_sub_word (
        .word_i (rot_w),
        .word_o (sub_w)
    );

    assign t_w = sub_w ^ {rcon_q, 24'h000000};

    // Each new word chains off the freshly computed previous word.
    assign n0 = w0 ^ t_w;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key = {n0, n1, n2, n3};

    // Valid is a pure function of state so it never depends on ready.
    assign roundKey_valid = (state_q == RUN);
    assign busy           = (state_q == RUN);
    assign round_idx      = idx_q;
    assign roundKey       = key_q;

    assign accept   = roundKey_valid & roundKey_ready;
    assign last_key = (idx_q == LAST_IDX);
    assign done     = accept & last_key;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key;
                    idx_d   = 4'd0;
                    rcon_d  = RCON_INIT;
                    state_d = RUN;
                end
            end
            RUN: begin
                // start is deliberately not looked at here: a start during
                // an expansion, including on the final accept, is dropped.
                if (accept) begin
                    if (last_key) begin
                        // Key register keeps the last round key; index and
                        // rcon return to their idle values.
                        idx_d   = 4'd0;
                        rcon_d  = RCON_INIT;
                        state_d = IDLE;
                    end else begin
                        key_d  = next_key;
                        idx_d  = idx_q + 4'd1;
                        rcon_d = xtime(rcon_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= 4'd0;
            rcon_q  <= RCON_INIT;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
        end
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb/tb_aes_key_schedule.sv - self-checking bench for aes_key_schedule

module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [0:127] key = '0;
    logic         busy;
    logic         roundKey_valid;
    logic         roundKey_ready = 1'b1;
    logic [3:0]   round_idx;
    logic [0:127] roundKey;
    logic         done;

    int           n_vec = 0;
    int           n_err = 0;
    int           launch_cnt = 0;
    bit           rnd_ready = 1'b0;
    logic [127:0] cur_keys [0:10];

    localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_ZERO = 128'h0;
    localparam logic [127:0] K_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;

    aes_key_schedule dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .key            (key),
        .busy           (busy),
        .roundKey_valid (roundKey_valid),
        .roundKey_ready (roundKey_ready),
        .round_idx      (round_idx),
        .roundKey       (roundKey),
        .done           (done)
    );

    initial forever #5 clk = ~clk;

    // GF(2^8) reference arithmetic: S-box built from inverse + affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        if (x != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
            end
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc;
        {w0, w1, w2, w3} = k;
        rc = 8'h01;
        for (int i = 1; i <= r; i++) begin
            t  = {sb(w3[23:16]), sb(w3[15:8]), sb(w3[7:0]), sb(w3[31:24])} ^ {rc, 24'h0};
            w0 = w0 ^ t;
            w1 = w1 ^ w0;
            w2 = w2 ^ w1;
            w3 = w3 ^ w2;
            rc = gmul(rc, 8'h02);
        end
        return {w0, w1, w2, w3};
    endfunction

    task automatic chkk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Consumer: ready either tied high or random per cycle.
    initial forever begin
        @(posedge clk);
        #1;
        roundKey_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Compare process: every cycle, outputs against the model.
    initial begin
        int           exp_next;
        int           seen;
        bit           stall;
        logic [127:0] stall_key;
        int           stall_idx;
        exp_next  = 0;
        seen      = 0;
        stall     = 1'b0;
        stall_key = '0;
        stall_idx = 0;
        forever begin
            @(negedge clk);
            if (launch_cnt != seen) begin
                seen     = launch_cnt;
                exp_next = 0;
            end
            if (rst) begin
                chkb("rst_valid", roundKey_valid, 1'b0);
                chkb("rst_busy", busy, 1'b0);
                chkb("rst_done", done, 1'b0);
                chki("rst_idx", int'(round_idx), 0);
                chkk("rst_key", roundKey, '0);
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chkb("hold_valid", roundKey_valid, 1'b1);
                    chki("hold_idx", int'(round_idx), stall_idx);
                    chkk("hold_key", roundKey, stall_key);
                end
                chkb("done", done, roundKey_valid && roundKey_ready && (round_idx == 4'd10));
                chkb("busy", busy, roundKey_valid);
                if (roundKey_valid) begin
                    if (exp_next > 10) begin
                        chkb("extra_valid", roundKey_valid, 1'b0);
                    end else begin
                        chki("idx", int'(round_idx), exp_next);
                        chkk("key", roundKey, cur_keys[exp_next]);
                    end
                    stall     = !roundKey_ready;
                    stall_key = roundKey;
                    stall_idx = int'(round_idx);
                    if (roundKey_ready) exp_next++;
                end else begin
                    chki("idle_idx", int'(round_idx), 0);
                    stall = 1'b0;
                end
            end
        end
    end

    task automatic launch(input logic [127:0] k);
        @(posedge clk);
        #1;
        for (int r = 0; r <= 10; r++) cur_keys[r] = round_key(k, r);
        key   = k;
        start = 1'b1;
        launch_cnt++;
        @(posedge clk);
        #1;
        start = 1'b0;
        key   = ~k;
        @(negedge clk);
        chkb("key0_latency_valid", roundKey_valid, 1'b1);
        chki("key0_latency_idx", int'(round_idx), 0);
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (done) break;
            if (cyc >= budget) begin
                n_vec++;
                n_err++;
                $display("FAIL wait_done: no done after %0d cycles", cyc);
                break;
            end
        end
    endtask

    task automatic wait_idx(input int target, input int budget);
        int cyc;
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (roundKey_valid && int'(round_idx) == target) break;
            if (cyc >= budget) begin
                n_vec++;
                n_err++;
                $display("FAIL wait_idx: idx %0d not seen after %0d cycles", target, cyc);
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;

        // Model pinned against published vectors.
        chkk("model_fips_k1", round_key(K_FIPS, 1), 128'ha0fafe1788542cb123a339392a6c7605);
        chkk("model_fips_k10", round_key(K_FIPS, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chkk("model_zero_k1", round_key(K_ZERO, 1), 128'h62636363626363636263636362636363);
        chkk("model_zero_k10", round_key(K_ZERO, 10), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chkb("reset_valid", roundKey_valid, 1'b0);
        chkb("reset_busy", busy, 1'b0);
        chki("reset_idx", int'(round_idx), 0);
        chkk("reset_key", roundKey, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // FIPS-197 key, ready high: done 10 cycles after key 0.
        launch(K_FIPS);
        wait_done(40, cyc);
        chki("fips_done_cycle", cyc, 10);
        chki("fips_done_idx", int'(round_idx), 10);
        chkk("fips_k10", roundKey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Back-to-back: start on the cycle right after done.
        launch(K_ZERO);
        wait_done(40, cyc);
        chki("zero_done_cycle", cyc, 10);
        chkk("zero_k10", roundKey, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Random backpressure.
        rnd_ready = 1'b1;
        launch(K_SEQ);
        wait_done(400, cyc);
        chki("bp_done_idx", int'(round_idx), 10);
        rnd_ready = 1'b0;

        // start pulsed mid-run is ignored.
        launch(K_FIPS);
        wait_idx(5, 40);
        #1;
        start = 1'b1;
        key   = K_SEQ;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(40, cyc);
        chki("midstart_done_cycle", cyc, 5);
        chkk("midstart_k10", roundKey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // start coincident with the final accept is ignored.
        launch(K_ZERO);
        wait_idx(10, 40);
        chkb("late_start_done", done, 1'b1);
        #1;
        start = 1'b1;
        key   = K_SEQ;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chkb("late_start_valid", roundKey_valid, 1'b0);
        chkb("late_start_busy", busy, 1'b0);

        // Asynchronous reset mid-expansion.
        launch(K_SEQ);
        wait_idx(4, 40);
        #2;
        rst = 1'b1;
        #1;
        chkb("async_rst_valid", roundKey_valid, 1'b0);
        chkb("async_rst_busy", busy, 1'b0);
        chkb("async_rst_done", done, 1'b0);
        chki("async_rst_idx", int'(round_idx), 0);
        chkk("async_rst_key", roundKey, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        launch(K_FIPS);
        wait_done(40, cyc);
        chki("post_rst_done_cycle", cyc, 10);
        chkk("post_rst_k10", roundKey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
